cmd_dispatch: RTL and testbench

CMD_DISPATCH -- requirements
Module: cmd_dispatch

---
 rtl/cmd_dispatch_if.sv | 30 +++
 rtl/cmd_dispatch.sv | 140 ++++++++++++++
 tb/tb_cmd_dispatch.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_dispatch_if.sv
// Dispatcher bus: RX command FIFO read port plus the shared engine port.
// The dispatcher takes the master side; the FIFO and engines take the slave side.
interface cmd_dispatch_if;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_rdata;
  logic [3:0] eng_sel;
  logic       eng_start;
  logic [7:0] eng_cmd;
  logic [7:0] eng_len;
  logic [7:0] eng_data;
  logic       eng_valid;
  logic [3:0] eng_ready;
  logic [3:0] eng_done;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  modport master (
    input  fifo_empty, fifo_rdata, eng_ready, eng_done,
    output fifo_rd, eng_sel, eng_start, eng_cmd, eng_len, eng_data, eng_valid,
           busy, err, err_code
  );

  modport slave (
    output fifo_empty, fifo_rdata, eng_ready, eng_done,
    input  fifo_rd, eng_sel, eng_start, eng_cmd, eng_len, eng_data, eng_valid,
           busy, err, err_code
  );
endinterface

// File: rtl/cmd_dispatch.sv
// Command dispatcher: pops header/length/payload frames from the RX FIFO and
// hands them to one of four engines, with per-state stall timeout.
module cmd_dispatch #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  cmd_dispatch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, HDR_WAIT, LEN_REQ, LEN_WAIT, DAT_REQ, DAT_WAIT, DAT_PUSH, DONE_WAIT
  } state_t;

  localparam logic [1:0]  ERR_PAGE    = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;
  localparam logic [1:0]  ERR_EARLY   = 2'b11;
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [15:0] tcnt;
  logic [7:0]  remain;
  logic [3:0]  hdr_sel;
  logic        sel_ready;
  logic        sel_done;
  logic        early_done;
  logic        stalled;

  function automatic logic [3:0] decode_page(input logic [3:0] page);
    case (page)
      4'h1:       return 4'b0001;
      4'h3, 4'h4: return 4'b0010;
      4'h5:       return 4'b0100;
      4'h7:       return 4'b1000;
      default:    return 4'b0000;
    endcase
  endfunction

  // eng_sel is one-hot, so masking picks out the selected engine's bit.
  assign hdr_sel    = decode_page(bus.fifo_rdata[7:4]);
  assign sel_ready  = |(bus.eng_ready & bus.eng_sel);
  assign sel_done   = |(bus.eng_done & bus.eng_sel);
  assign early_done = sel_done && (state inside {DAT_REQ, DAT_WAIT, DAT_PUSH});
  assign stalled    = (state != IDLE) && (tcnt == TMO_LAST);

  // NOTE: every register here is written with <= so all branches see the
  // pre-edge values; the pulse outputs are defaulted low each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      tcnt          <= '0;
      remain        <= '0;
      bus.fifo_rd   <= 1'b0;
      bus.eng_sel   <= '0;
      bus.eng_start <= 1'b0;
      bus.eng_cmd   <= '0;
      bus.eng_len   <= '0;
      bus.eng_data  <= '0;
      bus.eng_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
      bus.err_code  <= '0;
    end else begin
      bus.fifo_rd   <= 1'b0;
      bus.eng_start <= 1'b0;
      bus.err       <= 1'b0;
      tcnt          <= (state == IDLE) ? 16'd0 : tcnt + 16'd1;

      if (early_done || stalled) begin
        state         <= IDLE;
        tcnt          <= '0;
        bus.busy      <= 1'b0;
        bus.eng_sel   <= '0;
        bus.eng_valid <= 1'b0;
        bus.err       <= 1'b1;
        bus.err_code  <= early_done ? ERR_EARLY : ERR_TIMEOUT;
      end else begin
        // fifo_rdata is only valid once the registered fifo_rd has dropped,
        // so each *_WAIT state idles for the cycle in which the pop happens.
        unique case (state)
          IDLE: if (!bus.fifo_empty) begin
            bus.fifo_rd <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= HDR_WAIT;
          end
          HDR_WAIT: if (!bus.fifo_rd) begin
            tcnt <= '0;
            if (hdr_sel != 4'b0000) begin
              bus.eng_cmd <= bus.fifo_rdata;
              bus.eng_sel <= hdr_sel;
              state       <= LEN_REQ;
            end else begin
              bus.err      <= 1'b1;
              bus.err_code <= ERR_PAGE;
              bus.busy     <= 1'b0;
              state        <= IDLE;
            end
          end
          LEN_REQ: if (!bus.fifo_empty) begin
            bus.fifo_rd <= 1'b1;
            tcnt        <= '0;
            state       <= LEN_WAIT;
          end
          LEN_WAIT: if (!bus.fifo_rd) begin
            bus.eng_len   <= bus.fifo_rdata;
            remain        <= bus.fifo_rdata;
            bus.eng_start <= 1'b1;
            tcnt          <= '0;
            state         <= (bus.fifo_rdata == 8'd0) ? DONE_WAIT : DAT_REQ;
          end
          DAT_REQ: if (!bus.fifo_empty) begin
            bus.fifo_rd <= 1'b1;
            tcnt        <= '0;
            state       <= DAT_WAIT;
          end
          DAT_WAIT: if (!bus.fifo_rd) begin
            bus.eng_data  <= bus.fifo_rdata;
            bus.eng_valid <= 1'b1;
            tcnt          <= '0;
            state         <= DAT_PUSH;
          end
          DAT_PUSH: if (sel_ready) begin
            bus.eng_valid <= 1'b0;
            remain        <= remain - 8'd1;
            tcnt          <= '0;
            state         <= (remain == 8'd1) ? DONE_WAIT : DAT_REQ;
          end
          DONE_WAIT: if (sel_done) begin
            bus.eng_sel <= '0;
            bus.busy    <= 1'b0;
            tcnt        <= '0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch: stimulus queues expected engine events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cmd_dispatch;

  localparam int TMO = 16;

  typedef enum int {EV_START, EV_DATA, EV_ERR, EV_IDLE} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [3:0] sel;
    logic [7:0] a;   // START: cmd, DATA: byte, ERR: code
    logic [7:0] b;   // START: len, ERR: pops since frame start
  } ev_t;

  logic clk;
  logic rst_n;
  cmd_dispatch_if bus ();

  cmd_dispatch #(.TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  ev_t         exp_q[$];
  logic [7:0]  fifo_q[$];
  int          pop_cnt  = 0;
  int          cyc      = 0;
  int          hs_cnt   = 0;
  int          hs_cyc   = 0;
  int          start_cnt = 0;
  int          err_cnt  = 0;
  int          valid_cnt = 0;
  bit          mon_en   = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_ev(ev_kind_t k, logic [3:0] s, logic [7:0] a, logic [7:0] b);
    ev_t e;
    e.kind = k; e.sel = s; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  // FIFO model: pop registered on the edge where fifo_rd is seen high.
  always @(posedge clk) begin
    if (bus.fifo_rd === 1'b1) begin
      check("pop_while_empty", 32'(fifo_q.size() == 0), 32'd0);
      if (fifo_q.size() != 0) begin
        bus.fifo_rdata <= fifo_q.pop_front();
        pop_cnt++;
      end
    end
  end

  always @(negedge clk) bus.fifo_empty <= (fifo_q.size() == 0);

  task automatic pop_cmp(input ev_kind_t k, output ev_t e, output bit ok);
    ok = 1'b0;
    e.kind = EV_IDLE; e.sel = '0; e.a = '0; e.b = '0;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 32'(k), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      ok = (k == e.kind);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    cyc++;
    if (mon_en) begin
      if (bus.eng_start) begin
        start_cnt++;
        pop_cmp(EV_START, e, ok);
        if (ok) begin
          check("start_sel", 32'(bus.eng_sel), 32'(e.sel));
          check("start_cmd", 32'(bus.eng_cmd), 32'(e.a));
          check("start_len", 32'(bus.eng_len), 32'(e.b));
        end
      end
      if (bus.eng_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0 || exp_q[0].kind != EV_DATA) begin
          check("valid_unexpected", 32'(bus.eng_valid), 32'd0);
        end else begin
          check("eng_data", 32'(bus.eng_data), 32'(exp_q[0].a));
          if (|(bus.eng_ready & bus.eng_sel)) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            hs_cyc = cyc;
          end
        end
      end
      if (bus.err) begin
        err_cnt++;
        pop_cmp(EV_ERR, e, ok);
        if (ok) begin
          check("err_code", 32'(bus.err_code), 32'(e.a));
          check("err_sel", 32'(bus.eng_sel), 32'd0);
          check("err_valid", 32'(bus.eng_valid), 32'd0);
          check("err_busy", 32'(bus.busy), 32'd0);
          check("err_pops", 32'(pop_cnt), 32'(e.b));
          // DAT_REQ is entered on the handshake edge and holds TMO full
          // cycles, so err shows one cycle later still.
          if (e.a == 8'h02) check("timeout_cycles", 32'(cyc - hs_cyc), 32'(TMO + 1));
        end
      end else if (prev_busy && !bus.busy) begin
        pop_cmp(EV_IDLE, e, ok);
        if (ok) begin
          check("idle_sel", 32'(bus.eng_sel), 32'd0);
          check("busy_after_done", 32'(prev_done), 32'd1);
        end
      end
    end
    prev_busy = bus.busy;
    prev_done = |bus.eng_done;
  end

  function automatic int get_cnt(input int which);
    case (which)
      0:       return hs_cnt;
      1:       return start_cnt;
      2:       return err_cnt;
      default: return valid_cnt;
    endcase
  endfunction

  // Bounded wait on a monitor counter; an expired bound is a failed check.
  task automatic wait_cnt(input string name, input int which, input int target);
    int t = 0;
    while (get_cnt(which) < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(get_cnt(which) >= target), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done(input logic [3:0] mask);
    @(posedge clk); #1 bus.eng_done = mask;
    @(posedge clk); #1 bus.eng_done = 4'b0000;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (bus.busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(bus.busy), 32'd0);
    cycles(2);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fifo_rd"},   32'(bus.fifo_rd),   32'd0);
    check({tag, "_eng_sel"},   32'(bus.eng_sel),   32'd0);
    check({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
    check({tag, "_eng_cmd"},   32'(bus.eng_cmd),   32'd0);
    check({tag, "_eng_len"},   32'(bus.eng_len),   32'd0);
    check({tag, "_eng_data"},  32'(bus.eng_data),  32'd0);
    check({tag, "_eng_valid"}, 32'(bus.eng_valid), 32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_err"},       32'(bus.err),       32'd0);
    check({tag, "_err_code"},  32'(bus.err_code),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n          = 1'b0;
    bus.eng_ready  = 4'b0000;
    bus.eng_done   = 4'b0000;
    bus.fifo_rdata = 8'h00;
    cycles(3);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // I2C frame, two payload bytes, engine always ready.
    pop_cnt = 0;
    expect_ev(EV_START, 4'b0001, 8'h12, 8'h02);
    expect_ev(EV_DATA,  4'b0001, 8'hAA, 8'h00);
    expect_ev(EV_DATA,  4'b0001, 8'hBB, 8'h00);
    expect_ev(EV_IDLE,  4'b0000, 8'h00, 8'h00);
    bus.eng_ready = 4'b0001;
    fifo_q.push_back(8'h12); fifo_q.push_back(8'h02);
    fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB);
    base = hs_cnt;
    wait_cnt("i2c_handshakes", 0, base + 2);
    cycles(1);
    pulse_done(4'b0001);
    wait_idle("i2c_idle");

    // I3C zero-length frame: start pulse, no payload.
    base = start_cnt;
    expect_ev(EV_START, 4'b0010, 8'h45, 8'h00);
    expect_ev(EV_IDLE,  4'b0000, 8'h00, 8'h00);
    bus.eng_ready = 4'b0010;
    fifo_q.push_back(8'h45); fifo_q.push_back(8'h00);
    wait_cnt("i3c_start", 1, base + 1);
    cycles(2);
    pulse_done(4'b0010);
    wait_idle("i3c_idle");

    // Bad page header, then an FPR frame straight behind it.
    pop_cnt = 0;
    expect_ev(EV_ERR,   4'b0000, 8'h01, 8'd1);
    expect_ev(EV_START, 4'b1000, 8'h71, 8'h01);
    expect_ev(EV_DATA,  4'b1000, 8'h5A, 8'h00);
    expect_ev(EV_IDLE,  4'b0000, 8'h00, 8'h00);
    bus.eng_ready = 4'b1000;
    fifo_q.push_back(8'h20); fifo_q.push_back(8'h71);
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h5A);
    base = hs_cnt;
    wait_cnt("fpr_handshake", 0, base + 1);
    cycles(2);
    pulse_done(4'b1000);
    wait_idle("fpr_idle");

    // Engine back-pressure: 0x33 must sit on eng_data for five stalled cycles.
    expect_ev(EV_START, 4'b0001, 8'h10, 8'h02);
    expect_ev(EV_DATA,  4'b0001, 8'h33, 8'h00);
    expect_ev(EV_DATA,  4'b0001, 8'h44, 8'h00);
    expect_ev(EV_IDLE,  4'b0000, 8'h00, 8'h00);
    bus.eng_ready = 4'b0000;
    fifo_q.push_back(8'h10); fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
    base = valid_cnt;
    wait_cnt("stall_valid", 3, base + 1);
    cycles(4);
    check("stall_no_handshake", 32'(exp_q[0].a), 32'h33);
    bus.eng_ready = 4'b0001;
    base = hs_cnt;
    wait_cnt("stall_handshakes", 0, base + 2);
    cycles(1);
    pulse_done(4'b0001);
    wait_idle("stall_idle");

    // Early done while the dispatcher waits on an empty FIFO for byte two.
    pop_cnt = 0;
    expect_ev(EV_START, 4'b0010, 8'h30, 8'h03);
    expect_ev(EV_DATA,  4'b0010, 8'h01, 8'h00);
    expect_ev(EV_ERR,   4'b0000, 8'h03, 8'd3);
    bus.eng_ready = 4'b0010;
    fifo_q.push_back(8'h30); fifo_q.push_back(8'h03); fifo_q.push_back(8'h01);
    base = hs_cnt;
    wait_cnt("early_handshake", 0, base + 1);
    cycles(2);
    base = err_cnt;
    pulse_done(4'b0010);
    wait_cnt("early_err", 2, base + 1);
    cycles(2);
    check("early_drained", 32'(exp_q.size()), 32'd0);

    // Timeout: SPI frame promises three bytes but only one arrives.
    pop_cnt = 0;
    expect_ev(EV_START, 4'b0100, 8'h50, 8'h03);
    expect_ev(EV_DATA,  4'b0100, 8'h11, 8'h00);
    expect_ev(EV_ERR,   4'b0000, 8'h02, 8'd3);
    bus.eng_ready = 4'b0100;
    fifo_q.push_back(8'h50); fifo_q.push_back(8'h03); fifo_q.push_back(8'h11);
    base = err_cnt;
    wait_cnt("timeout_err", 2, base + 1);
    cycles(2);
    check("timeout_drained", 32'(exp_q.size()), 32'd0);
    check("timeout_sticky_code", 32'(bus.err_code), 32'd2);

    // Reset glitch between edges, then a real reset during DAT_PUSH.
    expect_ev(EV_START, 4'b0001, 8'h12, 8'h01);
    expect_ev(EV_DATA,  4'b0001, 8'h77, 8'h00);
    bus.eng_ready = 4'b0000;
    fifo_q.push_back(8'h12); fifo_q.push_back(8'h01); fifo_q.push_back(8'h77);
    base = valid_cnt;
    wait_cnt("push_valid", 3, base + 1);
    @(posedge clk); #2 rst_n = 1'b0; #2 rst_n = 1'b1;
    @(negedge clk);
    check("glitch_busy", 32'(bus.busy), 32'd1);
    check("glitch_valid", 32'(bus.eng_valid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0; mon_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    exp_q.delete();
    fifo_q.delete();
    cycles(2);
    check("midreset_no_err", 32'(bus.err), 32'd0);
    mon_en = 1'b1;

    // Normal FPR frame after the abandoned one.
    expect_ev(EV_START, 4'b1000, 8'h7F, 8'h01);
    expect_ev(EV_DATA,  4'b1000, 8'hC3, 8'h00);
    expect_ev(EV_IDLE,  4'b0000, 8'h00, 8'h00);
    bus.eng_ready = 4'b1000;
    fifo_q.push_back(8'h7F); fifo_q.push_back(8'h01); fifo_q.push_back(8'hC3);
    base = hs_cnt;
    wait_cnt("post_reset_handshake", 0, base + 1);
    cycles(2);
    pulse_done(4'b1000);
    wait_idle("post_reset_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
